// File: rtl/td4x_pkg.sv
// Shared definitions for the td4x core: TD4 opcode values and helpers that
// split a ROM word {op, im} into its fields for any supported data width.
package td4x_pkg;

   // Widest data path the field helpers handle; instruction words are
   // zero-extended to MAX_DW+4 bits before slicing.
   localparam int MAX_DW = 64;

   localparam logic [3:0] OP_ADD_A   = 4'b0000;
   localparam logic [3:0] OP_MOV_A_B = 4'b0001;
   localparam logic [3:0] OP_IN_A    = 4'b0010;
   localparam logic [3:0] OP_MOV_A   = 4'b0011;
   localparam logic [3:0] OP_MOV_B_A = 4'b0100;
   localparam logic [3:0] OP_ADD_B   = 4'b0101;
   localparam logic [3:0] OP_IN_B    = 4'b0110;
   localparam logic [3:0] OP_MOV_B   = 4'b0111;
   localparam logic [3:0] OP_OUT_B   = 4'b1001;
   localparam logic [3:0] OP_OUT_IM  = 4'b1011;
   localparam logic [3:0] OP_JNC     = 4'b1110;
   localparam logic [3:0] OP_JMP     = 4'b1111;

   function automatic logic [3:0] instr_op(input logic [MAX_DW+3:0] instr, input int dw);
      logic [MAX_DW+3:0] shifted;
      shifted = instr >> dw;
      return shifted[3:0];
   endfunction

   function automatic logic [MAX_DW-1:0] instr_im(input logic [MAX_DW+3:0] instr, input int dw);
      return instr[MAX_DW-1:0] & ~({MAX_DW{1'b1}} << dw);
   endfunction

endpackage

// File: rtl/td4x_tick_gen.sv
// Clock-enable divider: one tick every TICK_DIV enabled clk cycles, so the
// core runs from the system clock without a derived clock domain.
module td4x_tick_gen #(
   parameter int TICK_DIV = 5000000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      tick  = en && (cnt_q == LAST);
      cnt_d = cnt_q;
      if (en) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/td4x_core.sv
// Parametrised TD4 core: decode, ALU and register file, executing one
// instruction from the external combinational ROM per divider tick.
module td4x_core
   import td4x_pkg::*;
#(
   parameter int DW       = 4,
   parameter int AW       = 4,
   parameter int TICK_DIV = 5000000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   output logic [AW-1:0]   instr_addr,
   input  logic [DW+3:0]   instr_data,
   input  logic [DW-1:0]   in_port,
   output logic [DW-1:0]   out_port,
   output logic            out_strobe,
   output logic            halted,
   output logic            carry
);

   logic tick;

   td4x_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .tick (tick)
   );

   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] b_q, b_d;
   logic [AW-1:0] pc_q, pc_d;
   logic          c_q, c_d;
   logic [DW-1:0] out_q, out_d;
   logic          strobe_q, strobe_d;
   logic          halted_q, halted_d;

   logic [MAX_DW+3:0] instr_ext;
   logic [3:0]        op;
   logic [DW-1:0]     im;
   logic [AW-1:0]     jmp_tgt;
   logic [AW-1:0]     pc_inc;
   logic [DW:0]       sum_a;
   logic [DW:0]       sum_b;

   assign instr_ext = (MAX_DW + 4)'(instr_data);
   assign op        = instr_op(instr_ext, DW);
   assign im        = DW'(instr_im(instr_ext, DW));
   assign jmp_tgt   = im[AW-1:0];
   assign pc_inc    = pc_q + 1'b1;
   assign sum_a     = {1'b0, a_q} + {1'b0, im};
   assign sum_b     = {1'b0, b_q} + {1'b0, im};

   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      pc_d     = pc_q;
      c_d      = c_q;
      out_d    = out_q;
      strobe_d = 1'b0;
      halted_d = halted_q;

      if (tick && !halted_q) begin
         pc_d = pc_inc;
         c_d  = 1'b0;
         case (op)
            OP_ADD_A:   {c_d, a_d} = sum_a;
            OP_ADD_B:   {c_d, b_d} = sum_b;
            OP_MOV_A:   a_d = im;
            OP_MOV_B:   b_d = im;
            OP_MOV_A_B: a_d = b_q;
            OP_MOV_B_A: b_d = a_q;
            OP_IN_A:    a_d = in_port;
            OP_IN_B:    b_d = in_port;
            OP_OUT_B: begin
               out_d    = b_q;
               strobe_d = 1'b1;
            end
            OP_OUT_IM: begin
               out_d    = im;
               strobe_d = 1'b1;
            end
            OP_JMP: begin
               pc_d     = jmp_tgt;
               halted_d = (jmp_tgt == pc_q);
            end
            OP_JNC: begin
               // JNC sees the carry left by the previous instruction (c_q).
               if (!c_q) begin
                  pc_d     = jmp_tgt;
                  halted_d = (jmp_tgt == pc_q);
               end
            end
            default:    c_d = c_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q      <= '0;
         b_q      <= '0;
         pc_q     <= '0;
         c_q      <= 1'b0;
         out_q    <= '0;
         strobe_q <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         pc_q     <= pc_d;
         c_q      <= c_d;
         out_q    <= out_d;
         strobe_q <= strobe_d;
         halted_q <= halted_d;
      end
   end

   assign instr_addr = pc_q;
   assign out_port   = out_q;
   assign out_strobe = strobe_q;
   assign halted     = halted_q;
   assign carry      = c_q;

endmodule

// File: tb/tb_td4x_core.sv
// Bench for td4x_core: three instances (slow divider, DW=4 fast, DW=8 fast)
// with directed programs plus random programs against a behavioural model.
module tb_td4x_core;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b0;
   logic [7:0] in_w = '0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Instance d: DW=4, AW=4, TICK_DIV=3
   logic [7:0] rom_d [16];
   logic [3:0] addr_d, out_d;
   logic [7:0] instr_d;
   logic       stb_d, halt_d, c_d;
   assign instr_d = rom_d[addr_d];

   td4x_core #(.DW(4), .AW(4), .TICK_DIV(3)) u_d (
      .clk(clk), .rst(rst), .en(en), .instr_addr(addr_d), .instr_data(instr_d),
      .in_port(in_w[3:0]), .out_port(out_d), .out_strobe(stb_d), .halted(halt_d), .carry(c_d));

   // Instance n: DW=4, AW=4, TICK_DIV=1
   logic [7:0] rom_n [16];
   logic [3:0] addr_n, out_n;
   logic [7:0] instr_n;
   logic       stb_n, halt_n, c_n;
   assign instr_n = rom_n[addr_n];

   td4x_core #(.DW(4), .AW(4), .TICK_DIV(1)) u_n (
      .clk(clk), .rst(rst), .en(en), .instr_addr(addr_n), .instr_data(instr_n),
      .in_port(in_w[3:0]), .out_port(out_n), .out_strobe(stb_n), .halted(halt_n), .carry(c_n));

   // Instance w: DW=8, AW=4, TICK_DIV=1
   logic [11:0] rom_w [16];
   logic [3:0]  addr_w;
   logic [7:0]  out_w;
   logic [11:0] instr_w;
   logic        stb_w, halt_w, c_w;
   assign instr_w = rom_w[addr_w];

   td4x_core #(.DW(8), .AW(4), .TICK_DIV(1)) u_w (
      .clk(clk), .rst(rst), .en(en), .instr_addr(addr_w), .instr_data(instr_w),
      .in_port(in_w), .out_port(out_w), .out_strobe(stb_w), .halted(halt_w), .carry(c_w));

   // Behavioural model state (plain integers)
   int ma, mb, mpc, mc, mout, mstb, mhalt;

   task automatic model_reset();
      ma = 0; mb = 0; mpc = 0; mc = 0; mout = 0; mstb = 0; mhalt = 0;
   endtask

   task automatic model_step(input int dw, input int aw, input int op, input int im, input int inp);
      int dmod, amod, sum, next_pc, next_c, tgt;
      dmod = 1 << dw;
      amod = 1 << aw;
      mstb = 0;
      if (mhalt != 0) return;
      next_pc = (mpc + 1) % amod;
      next_c  = 0;
      tgt     = im % amod;
      case (op)
         0:  begin sum = ma + im; ma = sum % dmod; next_c = sum / dmod; end
         5:  begin sum = mb + im; mb = sum % dmod; next_c = sum / dmod; end
         3:  ma = im;
         7:  mb = im;
         1:  ma = mb;
         4:  mb = ma;
         2:  ma = inp;
         6:  mb = inp;
         9:  begin mout = mb; mstb = 1; end
         11: begin mout = im; mstb = 1; end
         15: begin if (tgt == mpc) mhalt = 1; next_pc = tgt; end
         14: if (mc == 0) begin if (tgt == mpc) mhalt = 1; next_pc = tgt; end
         default: next_c = mc;
      endcase
      mpc = next_pc;
      mc  = next_c;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      en  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic tick_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 16; i++) rom_d[i] = 8'h80;
      rom_d[0] = 8'hB5;
      rom_d[1] = 8'hB6;
      rom_d[2] = 8'hB7;
      rst = 1'b0;
      en  = 1'b1;
      #2;
      total++;
      if ({addr_d, out_d, stb_d, halt_d, c_d} !== 11'h0) begin
         bad++;
         $display("FAIL reset_async got=%0h want=0", {addr_d, out_d, stb_d, halt_d, c_d});
      end
      @(negedge clk);
      rst = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         tick_edge();
         total++;
         if ({addr_d, out_d, stb_d, halt_d, c_d} !== 11'h0) begin
            bad++;
            $display("FAIL pre_first_tick edge=%0d got=%0h want=0", k, {addr_d, out_d, stb_d, halt_d, c_d});
         end
      end
      tick_edge();
      total++;
      if (addr_d !== 4'd1 || out_d !== 4'd5 || stb_d !== 1'b1) begin
         bad++;
         $display("FAIL first_tick addr=%0d out=%0d stb=%0b want addr=1 out=5 stb=1", addr_d, out_d, stb_d);
      end
      tick_edge();
      total++;
      if (stb_d !== 1'b0 || addr_d !== 4'd1) begin
         bad++;
         $display("FAIL strobe_one_cycle stb=%0b addr=%0d want stb=0 addr=1", stb_d, addr_d);
      end
      tick_edge();
      tick_edge();
      total++;
      if (addr_d !== 4'd2 || out_d !== 4'd6) begin
         bad++;
         $display("FAIL second_tick addr=%0d out=%0d want addr=2 out=6", addr_d, out_d);
      end
      en = 1'b0;
      repeat (5) tick_edge();
      en = 1'b1;
      tick_edge();
      tick_edge();
      total++;
      if (addr_d !== 4'd2) begin
         bad++;
         $display("FAIL en_hold_delay addr=%0d want=2", addr_d);
      end
      tick_edge();
      total++;
      if (addr_d !== 4'd3 || out_d !== 4'd7) begin
         bad++;
         $display("FAIL tick_after_hold addr=%0d out=%0d want addr=3 out=7", addr_d, out_d);
      end
   endtask

   task automatic test_carry_jnc();
      for (int i = 0; i < 16; i++) rom_n[i] = 8'h80;
      rom_n[0] = 8'h3E;
      rom_n[1] = 8'h01;
      rom_n[2] = 8'hE1;
      rom_n[3] = 8'hB7;
      do_reset();
      tick_edge();
      tick_edge();
      total++;
      if (u_n.a_q !== 4'd15 || c_n !== 1'b0) begin
         bad++;
         $display("FAIL add_to_15 a=%0d c=%0b want a=15 c=0", u_n.a_q, c_n);
      end
      tick_edge();
      tick_edge();
      total++;
      if (u_n.a_q !== 4'd0 || c_n !== 1'b1 || addr_n !== 4'd2) begin
         bad++;
         $display("FAIL add_wrap a=%0d c=%0b addr=%0d want a=0 c=1 addr=2", u_n.a_q, c_n, addr_n);
      end
      tick_edge();
      total++;
      if (addr_n !== 4'd3 || c_n !== 1'b0) begin
         bad++;
         $display("FAIL jnc_not_taken addr=%0d c=%0b want addr=3 c=0", addr_n, c_n);
      end
      tick_edge();
      total++;
      if (out_n !== 4'd7 || stb_n !== 1'b1 || addr_n !== 4'd4) begin
         bad++;
         $display("FAIL out_im out=%0d stb=%0b addr=%0d want out=7 stb=1 addr=4", out_n, stb_n, addr_n);
      end
      tick_edge();
      total++;
      if (stb_n !== 1'b0 || out_n !== 4'd7) begin
         bad++;
         $display("FAIL out_strobe_drop stb=%0b out=%0d want stb=0 out=7", stb_n, out_n);
      end
   endtask

   task automatic test_width();
      for (int i = 0; i < 16; i++) rom_w[i] = 12'h800;
      rom_w[0] = 12'h0C8;
      rom_w[1] = 12'h0C8;
      rom_w[2] = 12'hF1F;
      do_reset();
      tick_edge();
      tick_edge();
      total++;
      if (u_w.a_q !== 8'd144 || c_w !== 1'b1) begin
         bad++;
         $display("FAIL wide_add a=%0d c=%0b want a=144 c=1", u_w.a_q, c_w);
      end
      tick_edge();
      total++;
      if (addr_w !== 4'hF || c_w !== 1'b0 || halt_w !== 1'b0) begin
         bad++;
         $display("FAIL jmp_trunc addr=%0h c=%0b halt=%0b want addr=f c=0 halt=0", addr_w, c_w, halt_w);
      end
      tick_edge();
      total++;
      if (addr_w !== 4'h0) begin
         bad++;
         $display("FAIL wide_pc_wrap addr=%0h want=0", addr_w);
      end
   endtask

   task automatic test_in_mov_out();
      for (int i = 0; i < 16; i++) rom_n[i] = 8'h80;
      rom_n[0] = 8'h20;
      rom_n[1] = 8'h40;
      rom_n[2] = 8'h53;
      rom_n[3] = 8'h90;
      in_w = 8'h09;
      do_reset();
      repeat (4) tick_edge();
      total++;
      if (out_n !== 4'd12 || c_n !== 1'b0 || stb_n !== 1'b1) begin
         bad++;
         $display("FAIL in_mov_out out=%0d c=%0b stb=%0b want out=12 c=0 stb=1", out_n, c_n, stb_n);
      end
   endtask

   task automatic test_halt();
      for (int i = 0; i < 16; i++) rom_n[i] = 8'h80;
      rom_n[0] = 8'h33;
      rom_n[1] = 8'hF1;
      do_reset();
      tick_edge();
      tick_edge();
      total++;
      if (halt_n !== 1'b1 || addr_n !== 4'd1) begin
         bad++;
         $display("FAIL halt_set halt=%0b addr=%0d want halt=1 addr=1", halt_n, addr_n);
      end
      rom_n[1] = 8'hB9;
      in_w = 8'h0A;
      en = 1'b0;
      repeat (2) tick_edge();
      en = 1'b1;
      in_w = 8'h05;
      repeat (4) tick_edge();
      total++;
      if (halt_n !== 1'b1 || addr_n !== 4'd1 || out_n !== 4'd0 || stb_n !== 1'b0 || u_n.a_q !== 4'd3) begin
         bad++;
         $display("FAIL halt_frozen halt=%0b addr=%0d out=%0d stb=%0b a=%0d want 1,1,0,0,3",
                  halt_n, addr_n, out_n, stb_n, u_n.a_q);
      end
      #2;
      rst = 1'b0;
      #1;
      total++;
      if (halt_n !== 1'b0 || addr_n !== 4'd0) begin
         bad++;
         $display("FAIL halt_async_clear halt=%0b addr=%0d want halt=0 addr=0", halt_n, addr_n);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_nop_wrap();
      for (int i = 0; i < 16; i++) rom_n[i] = 8'h80;
      rom_n[0] = 8'h3F;
      rom_n[1] = 8'h01;
      rom_n[3] = 8'hFF;
      do_reset();
      repeat (3) tick_edge();
      total++;
      if (c_n !== 1'b1 || addr_n !== 4'd3) begin
         bad++;
         $display("FAIL nop_keeps_carry c=%0b addr=%0d want c=1 addr=3", c_n, addr_n);
      end
      tick_edge();
      total++;
      if (addr_n !== 4'd15 || c_n !== 1'b0) begin
         bad++;
         $display("FAIL jmp_15 addr=%0d c=%0b want addr=15 c=0", addr_n, c_n);
      end
      tick_edge();
      total++;
      if (addr_n !== 4'd0) begin
         bad++;
         $display("FAIL pc_wrap addr=%0d want=0", addr_n);
      end
   endtask

   task automatic test_random_n(input int trials, input int steps);
      logic [10:0] exp_v;
      for (int t = 0; t < trials; t++) begin
         for (int i = 0; i < 16; i++) rom_n[i] = 8'($urandom);
         model_reset();
         do_reset();
         for (int s = 0; s < steps; s++) begin
            in_w = 8'($urandom);
            model_step(4, 4, int'(rom_n[mpc][7:4]), int'(rom_n[mpc][3:0]), int'(in_w[3:0]));
            exp_v = {4'(mpc), 4'(mout), 1'(mstb), 1'(mhalt), 1'(mc)};
            tick_edge();
            total++;
            if ({addr_n, out_n, stb_n, halt_n, c_n} !== exp_v) begin
               bad++;
               $display("FAIL random_n trial=%0d step=%0d got pc/out/stb/halt/c=%0h want=%0h",
                        t, s, {addr_n, out_n, stb_n, halt_n, c_n}, exp_v);
            end
         end
      end
   endtask

   task automatic test_random_w(input int trials, input int steps);
      logic [14:0] exp_v;
      for (int t = 0; t < trials; t++) begin
         for (int i = 0; i < 16; i++) rom_w[i] = 12'($urandom);
         model_reset();
         do_reset();
         for (int s = 0; s < steps; s++) begin
            in_w = 8'($urandom);
            model_step(8, 4, int'(rom_w[mpc][11:8]), int'(rom_w[mpc][7:0]), int'(in_w));
            exp_v = {4'(mpc), 8'(mout), 1'(mstb), 1'(mhalt), 1'(mc)};
            tick_edge();
            total++;
            if ({addr_w, out_w, stb_w, halt_w, c_w} !== exp_v) begin
               bad++;
               $display("FAIL random_w trial=%0d step=%0d got pc/out/stb/halt/c=%0h want=%0h",
                        t, s, {addr_w, out_w, stb_w, halt_w, c_w}, exp_v);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         rom_d[i] = 8'h80;
         rom_n[i] = 8'h80;
         rom_w[i] = 12'h800;
      end
      test_reset();
      test_carry_jnc();
      test_width();
      test_in_mov_out();
      test_halt();
      test_nop_wrap();
      test_random_n(8, 40);
      test_random_w(8, 40);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/td4x_core.md
# td4x_core

Parametrised successor to the 4-bit TD4 CPU core. It uses the TD4 ISA with configurable data width and program-address width. Execution is paced by an internal clock-enable divider, not a derived clock, and the core adds an input port, an output strobe and a halt-on-self-jump detector. It sits between an external combinational program ROM and the board I/O (switches in, LEDs out).

## Interface
Parameters:
- `DW`, 4: data/register width and immediate-field width; ≥4.
- `AW`, 4: program-counter width; must satisfy AW ≤ DW.
- `TICK_DIV`, 5000000: clk cycles per executed instruction; ≥1.

Ports:
- `clk`, in, 1: single system clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `en`, in, 1: run enable; when 0 the divider holds and nothing executes.
- `instr_addr`, out, AW: fetch address; always equals PC.
- `instr_data`, in, 4+DW: combinational ROM word, {op[3:0], im[DW-1:0]}.
- `in_port`, in, DW: input port, sampled on IN instructions.
- `out_port`, out, DW: registered output port.
- `out_strobe`, out, 1: one-cycle pulse on the clk cycle after an OUT executes.
- `halted`, out, 1: high once a self-jump has executed.
- `carry`, out, 1: current carry flag C.

## Operation
- State: registers A and B (DW bits), PC (AW bits), C, out_port, halted, divider counter.
- Reset (rst=0, any time, asynchronous): A=B=0, PC=0, C=0, out_port=0, out_strobe=0, halted=0, counter=0. No instruction executes in the cycle rst rises.
- Opcodes. Unless stated otherwise, PC←PC+1 and C←0.
  - 0000 ADD A,im: {C,A}←A+im.
  - 0101 ADD B,im: {C,B}←B+im.
  - 0011 MOV A,im.
  - 0111 MOV B,im.
  - 0001 MOV A,B.
  - 0100 MOV B,A.
  - 0010 IN A: A←in_port.
  - 0110 IN B: B←in_port.
  - 1001 OUT B: out_port←B.
  - 1011 OUT im: out_port←im.
  - 1111 JMP im: PC←im[AW-1:0].
  - 1110 JNC im: PC←im[AW-1:0] if C==0, else PC+1.
  - Any other opcode is a NOP: PC+1, C unchanged.
- Arithmetic: ADD is modulo 2^DW, and C takes bit DW of the DW+1-bit sum. JNC tests C as left by the previous instruction.
- PC wraps from 2^AW−1 to 0.
- Halt:
  - A taken JMP or JNC whose target equals the current PC sets halted=1.
  - While halted, no register, flag, PC or port changes until reset; the divider keeps running.
- OUT sets out_strobe for exactly one clk cycle, even when the value is unchanged.

## Timing
- Divider:
  - When en=1, the counter counts 0..TICK_DIV−1 and tick=1 while counter==TICK_DIV−1; the counter then wraps to 0.
  - TICK_DIV=1 gives tick every cycle.
  - When en=0 the counter holds its value and tick=0.
- Execute: on the clk rising edge where tick=1 and halted=0, the core decodes instr_data and in_port as seen in that cycle and updates all state.
- Fetch: instr_addr changes in the same edge as PC; the ROM must settle within one clk period.
- Latency: 1 tick per instruction, so the first instruction executes TICK_DIV cycles after rst rises with en=1.
- out_port and out_strobe are registered; both change on the execute edge.
- If rst is asserted mid-tick, reset wins and the counter restarts from 0.

## Structure
- Package `td4x_pkg`: opcode localparams (OP_ADD_A … OP_JNC) and the instruction-field slicing helpers.
- Sub-module `td4x_tick_gen` (parameter TICK_DIV; ports clk, rst, en, tick): the divider.
- The decode/ALU/register file stays in td4x_core; the ROM is external.

## Test plan
- Reset and divider, TICK_DIV=3, en=1: first execute on the 3rd edge after rst rises; every out_* and carry is 0 before it; holding en=0 for 5 cycles delays the next tick by exactly 5.
- Carry and JNC, DW=4, TICK_DIV=1: program MOV A,14 / ADD A,1 / JNC 1 / OUT 7. A goes 15 then 0 with C=1. out_port=7, out_strobe pulses once, and PC=4 after the OUT executes.
- Width generality, DW=8, AW=4: ADD A,200 twice gives A=144, C=1. JMP 0x1F lands at PC=0xF because im is truncated to AW bits.
- IN/MOV/OUT B: in_port=9. Sequence IN A / MOV B,A / ADD B,3 / OUT B gives out_port=12 and C=0.
- Halt: JMP to own address sets halted=1. Changing in_port and en afterwards changes nothing. Asserting rst (low) mid-cycle clears halted and PC asynchronously, before the next clk edge.
- NOP and wrap: opcode 1000 leaves C=1 unchanged. A PC at 15 with AW=4 wraps to 0.
